// File: rtl/sme_driver_if.sv
// sme_driver_if: bundles the host-side buffer/command bus and the SME character/result bus.
// slave is the driver's view; master is the host-plus-SME side.
interface sme_driver_if;
  logic       wr_en;
  logic       wr_sel;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic       start;
  logic [5:0] str_len;
  logic [3:0] pat_len;
  logic       busy;
  logic       done;
  logic       res_match;
  logic [4:0] res_index;
  logic       timeout;
  logic [7:0] chardata;
  logic       isstring;
  logic       ispattern;
  logic       sme_valid;
  logic       sme_match;
  logic [4:0] sme_match_index;

  modport slave (
    input  wr_en, wr_sel, wr_addr, wr_data, start, str_len, pat_len,
    input  sme_valid, sme_match, sme_match_index,
    output busy, done, res_match, res_index, timeout,
    output chardata, isstring, ispattern
  );

  modport master (
    output wr_en, wr_sel, wr_addr, wr_data, start, str_len, pat_len,
    output sme_valid, sme_match, sme_match_index,
    input  busy, done, res_match, res_index, timeout,
    input  chardata, isstring, ispattern
  );
endinterface

// File: rtl/sme_driver.sv
// sme_driver: streams the string then pattern buffer to an SME and captures its match result.
// Define SME_DRV_TIMEOUT_EN to abort a WAIT that lasts TIMEOUT_CYC cycles.
module sme_driver #(
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input logic         clk_i,
  input logic         rst_ni,
  sme_driver_if.slave bus
);
  typedef enum logic [2:0] {IDLE, SEND_S, SEND_P, WAIT, FIN} state_e;

  state_e     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic [5:0] strLen_q, strLen_d;
  logic [3:0] patLen_q, patLen_d;
  logic       resMatch_q, resMatch_d;
  logic [4:0] resIndex_q, resIndex_d;
  logic       timeout_q, timeout_d;
  logic [7:0] strBuf [32];
  logic [7:0] patBuf [8];
  logic       busy;
  logic       accept;
  logic       waitExpired;

  assign busy   = (state_q != IDLE);
  assign accept = (state_q == IDLE) && bus.start && (bus.pat_len != 4'd0) &&
                  (bus.pat_len <= 4'd8) && (bus.str_len <= 6'd32);

  // Buffers are deliberately not reset so a host can reuse them across resets.
  always_ff @(posedge clk_i) begin
    if (bus.wr_en && !busy) begin
      if (bus.wr_sel) patBuf[bus.wr_addr[2:0]] <= bus.wr_data;
      else            strBuf[bus.wr_addr]      <= bus.wr_data;
    end
  end

`ifdef SME_DRV_TIMEOUT_EN
  localparam int unsigned WaitW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [WaitW-1:0] waitCnt_q, waitCnt_d;

  assign waitExpired = (waitCnt_q == WaitW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) waitCnt_q <= '0;
    else         waitCnt_q <= waitCnt_d;
  end
`else
  logic unusedTimeoutCyc;
  assign unusedTimeoutCyc = (TIMEOUT_CYC == 0);
  assign waitExpired      = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      strLen_q   <= '0;
      patLen_q   <= '0;
      resMatch_q <= 1'b0;
      resIndex_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      strLen_q   <= strLen_d;
      patLen_q   <= patLen_d;
      resMatch_q <= resMatch_d;
      resIndex_q <= resIndex_d;
      timeout_q  <= timeout_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    strLen_d   = strLen_q;
    patLen_d   = patLen_q;
    resMatch_d = resMatch_q;
    resIndex_d = resIndex_q;
    timeout_d  = timeout_q;
`ifdef SME_DRV_TIMEOUT_EN
    waitCnt_d  = '0;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          strLen_d = bus.str_len;
          patLen_d = bus.pat_len;
          cnt_d    = '0;
          state_d  = (bus.str_len != 6'd0) ? SEND_S : SEND_P;
        end
      end
      SEND_S: begin
        if (cnt_q == strLen_q - 6'd1) begin
          cnt_d   = '0;
          state_d = SEND_P;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      SEND_P: begin
        if (cnt_q == {2'b00, patLen_q} - 6'd1) begin
          cnt_d   = '0;
          state_d = WAIT;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      WAIT: begin
        if (bus.sme_valid) begin
          resMatch_d = bus.sme_match;
          resIndex_d = bus.sme_match_index;
          timeout_d  = 1'b0;
          state_d    = FIN;
        end else if (waitExpired) begin
          resMatch_d = 1'b0;
          resIndex_d = '0;
          timeout_d  = 1'b1;
          state_d    = FIN;
        end
`ifdef SME_DRV_TIMEOUT_EN
        else begin
          waitCnt_d = waitCnt_q + WaitW'(1);
        end
`endif
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Characters come straight from the buffers so a write accepted with start is already visible.
  always_comb begin
    bus.chardata  = 8'h00;
    bus.isstring  = 1'b0;
    bus.ispattern = 1'b0;
    if (state_q == SEND_S) begin
      bus.isstring = 1'b1;
      bus.chardata = strBuf[cnt_q[4:0]];
    end else if (state_q == SEND_P) begin
      bus.ispattern = 1'b1;
      bus.chardata  = patBuf[cnt_q[2:0]];
    end
  end

  assign bus.busy      = busy;
  assign bus.done      = (state_q == FIN);
  assign bus.res_match = resMatch_q;
  assign bus.res_index = resIndex_q;
  assign bus.timeout   = timeout_q;
endmodule
